// File: rtl/sram_wport_arbiter.sv
// Round-robin arbiter sharing one SRAM write port among four requesters.
// Optional grant locking is compiled in with `define WARB_LOCK_EN.
module sram_wport_arbiter #(
    parameter int AW   = 16,
    parameter int DW   = 128,
    parameter int NREQ = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic                 WE,
    output logic [AW-1:0]        WriteAddress,
    output logic [DW-1:0]        WriteBus,
    output logic [1:0]           last_grant,
    output logic [15:0]          write_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
`ifdef WARB_LOCK_EN
    localparam logic [1:0] LOCKED = 2'd2;
`endif

    logic [1:0]      state_q, state_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;
    logic [15:0]     count_q, count_d;

    logic [1:0]      rr_idx;
    logic            rr_found;
    logic [1:0]      cand;
    logic [1:0]      sel_idx;
    logic            sel_ok;
    logic            xfer;

    // Search begins one past the most recent grant and wraps modulo four.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = last_grant_q + 2'(k);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_idx = rr_idx;
        sel_ok  = rr_found;
`ifdef WARB_LOCK_EN
        // The locked owner is always the last requester that transferred.
        if (state_q == LOCKED) begin
            sel_idx = last_grant_q;
            sel_ok  = req_valid[last_grant_q];
        end
`endif
        req_ready = '0;
        if (reset_n && enable && sel_ok) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        state_d      = xfer ? ISSUE : IDLE;
        last_grant_d = xfer ? sel_idx : last_grant_q;
        count_d      = count_q + 16'(xfer);
`ifdef WARB_LOCK_EN
        if (xfer && req_lock[sel_idx]) begin
            state_d = LOCKED;
        end else if (!xfer && state_q == LOCKED && enable) begin
            state_d = LOCKED;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            waddr_q      <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            if (xfer) begin
                waddr_q <= req_addr[sel_idx*AW +: AW];
                wdata_q <= req_data[sel_idx*DW +: DW];
            end
        end
    end

`ifdef WARB_LOCK_EN
    // LOCKED can persist through idle cycles, so the write strobe needs its own flop.
    logic we_q;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            we_q <= 1'b0;
        end else begin
            we_q <= xfer;
        end
    end
    assign WE = we_q;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign WE = (state_q == ISSUE);
`endif

    assign WriteAddress = waddr_q;
    assign WriteBus     = wdata_q;
    assign last_grant   = last_grant_q;
    assign write_count  = count_q;

endmodule

// File: tb/tb_sram_wport_arbiter.sv
// Self-checking bench for sram_wport_arbiter: vector table, directed corners,
// and random traffic against a queue-free arithmetic reference model.
module tb_sram_wport_arbiter;

    localparam int AW = 16;
    localparam int DW = 128;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [3:0]      req_valid;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_lock;
    logic [3:0]      req_ready;
    logic            WE;
    logic [AW-1:0]   WriteAddress;
    logic [DW-1:0]   WriteBus;
    logic [1:0]      last_grant;
    logic [15:0]     write_count;

    always #5 clock = ~clock;

    sram_wport_arbiter #(.AW(AW), .DW(DW), .NREQ(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .WE          (WE),
        .WriteAddress(WriteAddress),
        .WriteBus    (WriteBus),
        .last_grant  (last_grant),
        .write_count (write_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_last;
    bit           m_we;
    logic [15:0]  m_addr;
    logic [127:0] m_data;
    int           m_cnt;
    bit           m_lock;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [3:0]  v;
        logic [3:0]  rdy;
        logic [1:0]  lg;
        logic [15:0] cnt;
        logic        we;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int c;
        r = 4'b0;
        if (reset_n !== 1'b1 || enable !== 1'b1) return r;
        if (m_lock) begin
            if (req_valid[m_last]) r[m_last] = 1'b1;
            return r;
        end
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (req_valid[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_last = 3; m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_lock = 0;
    endtask

    task automatic model_edge(input logic [3:0] g);
        int i;
        if (!reset_n) begin
            model_reset();
            return;
        end
        i = -1;
        for (int k = 0; k < 4; k++) if (g[k]) i = k;
        if (i >= 0) begin
            m_we   = 1;
            m_addr = req_addr[i*AW +: AW];
            m_data = req_data[i*DW +: DW];
            m_last = i;
            m_cnt  = (m_cnt + 1) % 65536;
`ifdef WARB_LOCK_EN
            m_lock = req_lock[i];
`endif
        end else begin
            m_we = 0;
            if (!enable) m_lock = 0;
        end
    endtask

    task automatic check_regs(input string nm);
        chk({nm, ".WE"}, 128'(WE), 128'(m_we));
        chk({nm, ".addr"}, 128'(WriteAddress), 128'(m_addr));
        chk({nm, ".data"}, WriteBus, m_data);
        chk({nm, ".last_grant"}, 128'(last_grant), 128'(m_last));
        chk({nm, ".count"}, 128'(write_count), 128'(m_cnt));
    endtask

    // One clock: inputs already driven just after the previous edge.
    task automatic step(input string nm, input logic [3:0] exp_rdy, input bit use_exp);
        logic [3:0] g;
        #1;
        g = model_ready();
        chk({nm, ".ready_model"}, 128'(req_ready), 128'(g));
        if (use_exp) chk({nm, ".ready"}, 128'(req_ready), 128'(exp_rdy));
        @(posedge clock);
        model_edge(g);
        #1;
        check_regs(nm);
    endtask

    task automatic set_fixed_payload();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW] = 16'h0100 + 16'(i);
            req_data[i*DW +: DW] = {4{32'hDA7A0000 | 32'(i)}};
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; req_valid = '0; req_lock = '0;
        req_addr = '0; req_data = '0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        // Vector table
        tbl[0]  = '{1'b0, 1'b1, 4'hF,    4'b0000, 2'd3, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 16'd1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd2, 16'd1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 4'hF,    4'b1000, 2'd3, 16'd2, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 4'hF,    4'b0001, 2'd0, 16'd3, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 4'hF,    4'b0010, 2'd1, 16'd4, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 4'hF,    4'b0100, 2'd2, 16'd5, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 4'hF,    4'b0000, 2'd2, 16'd5, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 4'hF,    4'b1000, 2'd3, 16'd6, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'b0011, 4'b0001, 2'd0, 16'd7, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 4'b0011, 4'b0010, 2'd1, 16'd8, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 4'b1001, 4'b1000, 2'd3, 16'd9, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 4'hF,    4'b0000, 2'd3, 16'd0, 1'b0};

        set_fixed_payload();
        for (int t = 0; t < 13; t++) begin
            reset_n = tbl[t].rst_n; enable = tbl[t].en; req_valid = tbl[t].v;
            step($sformatf("tbl%0d", t), tbl[t].rdy, 1'b1);
            chk($sformatf("tbl%0d.lg", t), 128'(last_grant), 128'(tbl[t].lg));
            chk($sformatf("tbl%0d.cnt", t), 128'(write_count), 128'(tbl[t].cnt));
            chk($sformatf("tbl%0d.we", t), 128'(WE), 128'(tbl[t].we));
            if (tbl[t].we) chk($sformatf("tbl%0d.waddr", t), 128'(WriteAddress),
                               128'(16'h0100 + 16'(tbl[t].lg)));
        end

        // Single requester with spec payload
        reset_n = 1'b1; enable = 1'b1; req_valid = 4'b0000;
        step("settle", 4'b0000, 1'b1);
        req_addr[2*AW +: AW] = 16'h0010;
        req_data[2*DW +: DW] = {16{8'hA5}};
        req_valid = 4'b0100;
        step("single", 4'b0100, 1'b1);
        chk("single.WE", 128'(WE), 128'(1'b1));
        chk("single.addr", 128'(WriteAddress), 128'(16'h0010));
        chk("single.data", WriteBus, {16{8'hA5}});

        // Fairness after a clean reset
        set_fixed_payload();
        reset_n = 1'b0; req_valid = 4'hF;
        step("fair_rst", 4'b0000, 1'b1);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step($sformatf("fair%0d", k), 4'b0001 << (k % 4), 1'b1);
            chk($sformatf("fair%0d.WE", k), 128'(WE), 128'(1'b1));
        end
        chk("fair.count", 128'(write_count), 128'(16'd8));

        // Reset while a registered write is pending
        chk("midrst.pending", 128'(WE), 128'(1'b1));
        reset_n = 1'b0;
        step("midrst", 4'b0000, 1'b1);
        chk("midrst.WE", 128'(WE), 128'(1'b0));
        chk("midrst.count", 128'(write_count), 128'(16'd0));
        reset_n = 1'b1; req_valid = '0;

`ifdef WARB_LOCK_EN
        req_valid = 4'b0110; req_lock = 4'b0010;
        step("lock_a", 4'b0010, 1'b1);
        step("lock_b", 4'b0010, 1'b1);
        step("lock_c", 4'b0010, 1'b1);
        req_lock = 4'b0000;
        step("lock_end", 4'b0010, 1'b1);
        step("lock_next", 4'b0100, 1'b1);
        req_valid = '0;
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset_n   = ($urandom_range(0, 39) != 0);
            enable    = ($urandom_range(0, 99) < 85);
            req_valid = 4'($urandom);
            req_lock  = 4'($urandom);
            for (int w = 0; w < 2; w++) req_addr[w*32 +: 32] = $urandom;
            for (int w = 0; w < 16; w++) req_data[w*32 +: 32] = $urandom;
            step("rand", 4'b0000, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
